pool_window_buffer: RTL and testbench

- Upstream feeder for the 2x2 max-pooling stage.
- Accepts one conv-layer feature map as a raster-order pixel stream, one 8-bit pixel per valid cycle.
- Buffers one row and emits each non-overlapping 2x2 window (stride 2) as four parallel pixels plus a one-cycle valid strobe.
- The four window outputs and the strobe connect directly to the pooling stage's in1..in4 and enable.

---
 rtl/pool_window_buffer.sv | 87 ++++++++
 tb/tb_pool_window_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pool_window_buffer.sv
// Row-buffered 2x2 stride-2 window former feeding the max-pooling stage.
// Raster pixels in, one registered window (tl,tr,bl,br) plus strobe out per 2x2 block.
module pool_window_buffer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              win_valid,
    output logic [DATA_W-1:0] win_tl,
    output logic [DATA_W-1:0] win_tr,
    output logic [DATA_W-1:0] win_bl,
    output logic [DATA_W-1:0] win_br,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {
        ROW_EVEN,
        ROW_ODD
    } state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] linebuf [IMG_W];
    logic [DATA_W-1:0] left;

    logic          accept;
    logic          row_end;
    logic [CW-1:0] col_pair;

    assign accept   = in_valid && !rst;
    assign row_end  = (col == COL_LAST);
    // col is odd when a window forms, so its even partner is col with bit 0 cleared
    assign col_pair = col ^ CW'(1);

    // Storage is never cleared: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (accept && state == ROW_EVEN)
            linebuf[col] <= in_data;
        if (accept && state == ROW_ODD && !col[0])
            left <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ROW_EVEN;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_tl     <= '0;
            win_tr     <= '0;
            win_bl     <= '0;
            win_br     <= '0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (state == ROW_ODD && col[0]) begin
                    win_tl     <= linebuf[col_pair];
                    win_tr     <= linebuf[col];
                    win_bl     <= left;
                    win_br     <= in_data;
                    win_valid  <= 1'b1;
                    frame_done <= row_end && (row == ROW_LAST);
                end
                if (row_end) begin
                    col   <= '0;
                    row   <= (row == ROW_LAST) ? '0 : row + RW'(1);
                    state <= (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Self-checking bench for pool_window_buffer: 4x4 directed frames and a random 28x28 frame
// against a pixel-array reference model.
module tb_pool_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, v4 = 1'b0;
    logic [7:0] d4 = '0;
    logic       wv4, fd4;
    logic [7:0] tl4, tr4, bl4, br4;

    logic       rst28 = 1'b1, v28 = 1'b0;
    logic [7:0] d28 = '0;
    logic       wv28, fd28;
    logic [7:0] tl28, tr28, bl28, br28;

    pool_window_buffer #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(v4), .in_data(d4),
        .win_valid(wv4), .win_tl(tl4), .win_tr(tr4), .win_bl(bl4), .win_br(br4),
        .frame_done(fd4)
    );

    pool_window_buffer #(.IMG_W(28), .IMG_H(28), .DATA_W(8)) dut28 (
        .clk(clk), .rst(rst28), .in_valid(v28), .in_data(d28),
        .win_valid(wv28), .win_tl(tl28), .win_tr(tr28), .win_bl(bl28), .win_br(br28),
        .frame_done(fd28)
    );

    int tests = 0;
    int failed = 0;

    // Reference model: pixels of the current frame in a flat array, indexed by arrival order.
    bit         sel;
    int         W, H;
    int         mcount;
    logic [7:0] pix [0:28*28-1];
    logic [7:0] e_tl, e_tr, e_bl, e_br;
    int         nwin, nfd;
    logic [31:0] winq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] max4(input logic [7:0] a, b, c, d);
        logic [7:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic cycle(input bit r, input bit v, input logic [7:0] d);
        int row, col;
        bit exp_v, exp_fd;
        logic [7:0] exp_max;
        logic ov, ofd;
        logic [7:0] o_tl, o_tr, o_bl, o_br;
        if (sel) begin rst28 = r; v28 = v; d28 = d; end
        else     begin rst4  = r; v4  = v; d4  = d; end
        @(posedge clk);
        #1;
        exp_v = 0; exp_fd = 0; exp_max = '0;
        if (r) begin
            mcount = 0;
            e_tl = '0; e_tr = '0; e_bl = '0; e_br = '0;
        end else if (v) begin
            row = mcount / W;
            col = mcount % W;
            pix[mcount] = d;
            if (row % 2 == 1 && col % 2 == 1) begin
                exp_v  = 1;
                e_tl   = pix[mcount - W - 1];
                e_tr   = pix[mcount - W];
                e_bl   = pix[mcount - 1];
                e_br   = d;
                exp_fd = (mcount == W * H - 1);
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (pix[(row - 1 + dr) * W + col - 1 + dc] > exp_max)
                            exp_max = pix[(row - 1 + dr) * W + col - 1 + dc];
            end
            mcount = (mcount + 1) % (W * H);
        end
        if (sel) begin ov = wv28; ofd = fd28; o_tl = tl28; o_tr = tr28; o_bl = bl28; o_br = br28; end
        else     begin ov = wv4;  ofd = fd4;  o_tl = tl4;  o_tr = tr4;  o_bl = bl4;  o_br = br4;  end
        chk("win_valid", 32'(ov), 32'(exp_v));
        chk("frame_done", 32'(ofd), 32'(exp_fd));
        chk("win_tl", 32'(o_tl), 32'(e_tl));
        chk("win_tr", 32'(o_tr), 32'(e_tr));
        chk("win_bl", 32'(o_bl), 32'(e_bl));
        chk("win_br", 32'(o_br), 32'(e_br));
        if (ov === 1'b1) begin
            nwin++;
            if (ofd === 1'b1) nfd++;
            winq.push_back({o_tl, o_tr, o_bl, o_br});
            if (exp_v) chk("pool_max", 32'(max4(o_tl, o_tr, o_bl, o_br)), 32'(exp_max));
        end
    endtask

    task automatic do_reset();
        // in_valid held high during reset must be ignored
        cycle(1, 1, 8'($urandom));
        cycle(1, 1, 8'($urandom));
    endtask

    task automatic send_frame(input int base, input bit gaps, input bit rnd);
        int n;
        for (int k = 0; k < W * H; k++) begin
            if (gaps) begin
                n = (k == 5 || k % W == 0 || k % W == W - 1) ? 1 + $urandom_range(0, 2)
                                                             : $urandom_range(0, 1);
                for (int g = 0; g < n; g++) cycle(0, 0, 8'($urandom));
            end
            cycle(0, 1, rnd ? 8'($urandom) : 8'(base + k));
        end
    endtask

    initial begin
        sel = 0; W = 4; H = 4; mcount = 0;
        e_tl = '0; e_tr = '0; e_bl = '0; e_br = '0;
        nwin = 0; nfd = 0;

        // 4x4 ramp, continuous
        do_reset();
        winq.delete(); nwin = 0; nfd = 0;
        send_frame(0, 0, 0);
        cycle(0, 0, 8'h00);
        chk("ramp_count", 32'(winq.size()), 32'd4);
        chk("ramp_fd_count", 32'(nfd), 32'd1);
        if (winq.size() == 4) begin
            chk("ramp_w0", winq[0], 32'h00010405);
            chk("ramp_w1", winq[1], 32'h02030607);
            chk("ramp_w2", winq[2], 32'h08090c0d);
            chk("ramp_w3", winq[3], 32'h0a0b0e0f);
        end

        // Same ramp with stream gaps
        winq.delete(); nwin = 0; nfd = 0;
        send_frame(0, 1, 0);
        cycle(0, 0, 8'h00);
        chk("gap_count", 32'(winq.size()), 32'd4);
        if (winq.size() == 4) begin
            chk("gap_w0", winq[0], 32'h00010405);
            chk("gap_w3", winq[3], 32'h0a0b0e0f);
        end

        // Back-to-back frames, no idle between
        winq.delete(); nwin = 0; nfd = 0;
        send_frame(0, 0, 0);
        send_frame(100, 0, 0);
        cycle(0, 0, 8'h00);
        chk("b2b_count", 32'(nwin), 32'd8);
        chk("b2b_fd_count", 32'(nfd), 32'd2);
        if (winq.size() == 8) chk("b2b_w4", winq[4], 32'h64656869);

        // Reset after 9 pixels of a frame
        for (int k = 0; k < 9; k++) cycle(0, 1, 8'(200 + k));
        do_reset();
        winq.delete(); nwin = 0; nfd = 0;
        send_frame(50, 0, 0);
        cycle(0, 0, 8'h00);
        chk("rst_count", 32'(nwin), 32'd4);
        if (winq.size() == 4) chk("rst_w0", winq[0], 32'h32333637);

        // 28x28 random frame with random gaps
        v4 = 0; rst4 = 0;
        sel = 1; W = 28; H = 28;
        do_reset();
        winq.delete(); nwin = 0; nfd = 0;
        send_frame(0, 1, 1);
        cycle(0, 0, 8'h00);
        cycle(0, 0, 8'h00);
        chk("big_count", 32'(nwin), 32'd196);
        chk("big_fd_count", 32'(nfd), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
